// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter slice: opcodes, FSM state
// encoding and the bit positions of the packed flag vector.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CARRY    = 3;
    localparam int BORROW   = 2;
    localparam int OVERFLOW = 1;
    localparam int ZERO     = 0;

endpackage

// File: rtl/alu_8_bit.sv
// 8-bit combinational ALU. Ports: a, b, opcode in; out, carry,
// borrow, overflow, zero out. Logic ops clear carry/borrow/overflow.
module alu_8_bit
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] opcode,
    output logic [7:0] out,
    output logic       carry,
    output logic       borrow,
    output logic       overflow,
    output logic       zero
);

    logic [8:0] wide;

    always_comb begin
        out      = 8'h00;
        carry    = 1'b0;
        borrow   = 1'b0;
        overflow = 1'b0;
        wide     = 9'h000;
        case (opcode)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                out      = wide[7:0];
                carry    = wide[8];
                overflow = (a[7] == b[7]) && (out[7] != a[7]);
            end
            OP_SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                out      = wide[7:0];
                borrow   = wide[8];
                overflow = (a[7] != b[7]) && (out[7] != a[7]);
            end
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_SHL: out = a << b[2:0];
            OP_SHR: out = a >> b[2:0];
            default: out = a;
        endcase
    end

    assign zero = (out == 8'h00);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one alu_8_bit: IDLE -> EXEC -> RESP.
// Ports: clk, rst, req0/1 {valid,ready,a,b,opcode}, resp {valid,ready,
// id,out,flags}, busy. ALU_ARB_ROUND_ROBIN_EN selects round-robin.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_opcode,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_opcode,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_out,
    output logic [3:0] resp_flags,
    output logic       busy
);

    state_t     state;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [2:0] op_q;
    logic       id_q;
    logic       g0;
    logic       g1;
    logic       accept;

    logic [7:0] alu_out;
    logic       alu_c;
    logic       alu_b;
    logic       alu_v;
    logic       alu_z;
    logic [3:0] alu_flags;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On contention the requester that did not win last time goes.
    always_comb begin
        g0 = req0_valid && (!req1_valid || last_grant);
        g1 = req1_valid && (!req0_valid || !last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= req1_ready;
    end
`else
    always_comb begin
        g0 = req0_valid;
        g1 = req1_valid && !req0_valid;
    end
`endif

    assign req0_ready = (state == IDLE) && g0;
    assign req1_ready = (state == IDLE) && g1;
    assign accept     = req0_ready || req1_ready;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    alu_8_bit u_alu (
        .a        (a_q),
        .b        (b_q),
        .opcode   (op_q),
        .out      (alu_out),
        .carry    (alu_c),
        .borrow   (alu_b),
        .overflow (alu_v),
        .zero     (alu_z)
    );

    always_comb begin
        alu_flags           = 4'h0;
        alu_flags[CARRY]    = alu_c;
        alu_flags[BORROW]   = alu_b;
        alu_flags[OVERFLOW] = alu_v;
        alu_flags[ZERO]     = alu_z;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            op_q       <= 3'b000;
            id_q       <= 1'b0;
            resp_id    <= 1'b0;
            resp_out   <= 8'h00;
            resp_flags <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= req1_ready ? req1_a : req0_a;
                        b_q   <= req1_ready ? req1_b : req0_b;
                        op_q  <= req1_ready ? req1_opcode : req0_opcode;
                        id_q  <= req1_ready;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_out   <= alu_out;
                    resp_flags <= alu_flags;
                    resp_id    <= id_q;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an expected-response queue.
// Build with ALU_ARB_ROUND_ROBIN_EN defined to check the round-robin build.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req0_a = 8'h00;
    logic [7:0] req0_b = 8'h00;
    logic [2:0] req0_opcode = 3'b000;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] req1_a = 8'h00;
    logic [7:0] req1_b = 8'h00;
    logic [2:0] req1_opcode = 3'b000;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic       resp_id;
    logic [7:0] resp_out;
    logic [3:0] resp_flags;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit r1_seen = 0;

    typedef struct {
        logic       id;
        logic [7:0] out;
        logic [3:0] flags;
        logic [3:0] mask;
    } exp_t;

    exp_t sbq[$];
    logic got_ids[$];
    int   acc_cyc[$];

    alu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_opcode (req0_opcode),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_opcode (req1_opcode),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_out    (resp_out),
        .resp_flags  (resp_flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference behaviour for the opcodes exercised here.
    // Flags: {carry, borrow, overflow, zero}.
    function automatic exp_t model(logic id, logic [7:0] a,
                                   logic [7:0] b, logic [2:0] op);
        exp_t e;
        logic [8:0] s;
        e.id = id;
        e.out = 8'h00;
        e.flags = 4'h0;
        e.mask = 4'h0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                e.out = s[7:0];
                e.flags = {s[8], 1'b0,
                           (a[7] == b[7]) && (s[7] != a[7]),
                           s[7:0] == 8'h00};
                e.mask = 4'hF;
            end
            3'b010: begin
                e.out = a & b;
                e.flags = {3'b000, e.out == 8'h00};
                e.mask = 4'b0001;
            end
            3'b101: begin
                e.out = a << b[2:0];
                e.flags = {3'b000, e.out == 8'h00};
                e.mask = 4'b0001;
            end
            default: e.mask = 4'h0;
        endcase
        return e;
    endfunction

    // Mid-cycle observation: record accepts, pop and check responses.
    task automatic observe();
        exp_t e;
        if (req0_ready || req1_ready) begin
            checks++;
            if ((req0_ready && req1_ready) || (req0_ready && !req0_valid)
                || (req1_ready && !req1_valid)) begin
                errors++;
                $display("FAIL grant_legal: r0=%b r1=%b v0=%b v1=%b",
                         req0_ready, req1_ready, req0_valid, req1_valid);
            end
        end
        if (req1_ready)
            r1_seen = 1;
        if (req0_valid && req0_ready) begin
            sbq.push_back(model(1'b0, req0_a, req0_b, req0_opcode));
            acc_cyc.push_back(cyc);
        end
        if (req1_valid && req1_ready) begin
            sbq.push_back(model(1'b1, req1_a, req1_b, req1_opcode));
            acc_cyc.push_back(cyc);
        end
        if (resp_valid && resp_ready) begin
            checks++;
            got_ids.push_back(resp_id);
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: id=%0d out=%h",
                         resp_id, resp_out);
            end else begin
                e = sbq.pop_front();
                if (resp_id !== e.id || resp_out !== e.out ||
                    (resp_flags & e.mask) !== (e.flags & e.mask)) begin
                    errors++;
                    $display("FAIL resp_data: got id=%0d out=%h fl=%b want id=%0d out=%h fl=%b mask=%b",
                             resp_id, resp_out, resp_flags,
                             e.id, e.out, e.flags, e.mask);
                end
            end
        end
    endtask

    // Observe at the falling edge, return 1 time unit after rising edge.
    task automatic step();
        @(negedge clk);
        if (!rst)
            observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (sbq.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_timeout: pending=%0d busy=%b want 0 0",
                     name, sbq.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({resp_valid, resp_id, resp_out, resp_flags, busy,
             req0_ready, req1_ready} !== 17'h0) begin
            errors++;
            $display("FAIL reset_values: v=%b id=%b out=%h fl=%b busy=%b want all 0",
                     resp_valid, resp_id, resp_out, resp_flags, busy);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic do_single(input logic id, input logic [7:0] a,
                             input logic [7:0] b, input logic [2:0] op,
                             input logic [7:0] xout, input logic [3:0] xfl,
                             input string name);
        resp_ready = 1'b1;
        if (id) begin
            req1_a = a; req1_b = b; req1_opcode = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_opcode = op; req0_valid = 1'b1;
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_exec: busy=%b v=%b want 1 0",
                     name, busy, resp_valid);
        end
        step();
        checks++;
        if ({resp_valid, resp_id, resp_out, resp_flags} !==
            {1'b1, id, xout, xfl}) begin
            errors++;
            $display("FAIL %s_resp: v=%b id=%b out=%h fl=%b want 1 %b %h %b",
                     name, resp_valid, resp_id, resp_out, resp_flags,
                     id, xout, xfl);
        end
        wait_idle(name);
    endtask

    task automatic test_add_carry();
        do_single(1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, 4'b1001, "add_carry");
    endtask

    task automatic test_add_overflow();
        do_single(1'b1, 8'h7F, 8'h01, 3'b000, 8'h80, 4'b0010, "add_ovf");
    endtask

    task automatic test_reset_mid_exec();
        req0_a = 8'h01; req0_b = 8'h01; req0_opcode = 3'b000;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({resp_valid, resp_id, resp_out, resp_flags, busy} !== 15'h0) begin
            errors++;
            $display("FAIL reset_mid_exec: v=%b id=%b out=%h fl=%b busy=%b want all 0",
                     resp_valid, resp_id, resp_out, resp_flags, busy);
        end
        sbq.delete();
        acc_cyc.delete();
        step();
        step();
        rst = 1'b0;
        req0_a = 8'h0F; req0_b = 8'h01; req0_opcode = 3'b010;
        req1_a = 8'h0F; req1_b = 8'h01; req1_opcode = 3'b101;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_grant: r0=%b r1=%b want 1 0",
                     req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("first_grant");
    endtask

    task automatic test_contention();
        logic xid[4];
        int n;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        xid = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        xid = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        rst = 1'b1;
        #2;
        rst = 1'b0;
        got_ids.delete();
        acc_cyc.delete();
        r1_seen = 0;
        resp_ready = 1'b1;
        req0_a = 8'h0F; req0_b = 8'h01; req0_opcode = 3'b010;
        req1_a = 8'h0F; req1_b = 8'h01; req1_opcode = 3'b101;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        while (acc_cyc.size() < 4 && n < 40) begin
            step();
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("contention");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_ids.size()) begin
                errors++;
                $display("FAIL cont_id%0d: missing response, want id %0d",
                         i, xid[i]);
            end else if (got_ids[i] !== xid[i]) begin
                errors++;
                $display("FAIL cont_id%0d: got %0d want %0d",
                         i, got_ids[i], xid[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i + 1 >= acc_cyc.size()) begin
                errors++;
                $display("FAIL cont_gap%0d: missing accept, want gap 3", i);
            end else if (acc_cyc[i+1] - acc_cyc[i] != 3) begin
                errors++;
                $display("FAIL cont_gap%0d: got %0d want 3",
                         i, acc_cyc[i+1] - acc_cyc[i]);
            end
        end
`ifndef ALU_ARB_ROUND_ROBIN_EN
        checks++;
        if (r1_seen) begin
            errors++;
            $display("FAIL fixed_req1_ready: got 1 want 0");
        end
`endif
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req0_a = 8'hFF; req0_b = 8'h01; req0_opcode = 3'b000;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        req1_a = 8'h0F; req1_b = 8'h01; req1_opcode = 3'b101;
        req1_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({resp_valid, resp_id, resp_out, resp_flags,
                 req0_ready, req1_ready} !==
                {1'b1, 1'b0, 8'h00, 4'b1001, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall%0d: v=%b id=%b out=%h fl=%b r0=%b r1=%b want 1 0 00 1001 0 0",
                         i, resp_valid, resp_id, resp_out, resp_flags,
                         req0_ready, req1_ready);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if (req1_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_stall_ready: r1=%b busy=%b want 1 0",
                     req1_ready, busy);
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL post_stall_accept: busy=%b want 1", busy);
        end
        resp_ready = 1'b1;
        wait_idle("backpressure");
    endtask

    initial begin
        #1;
        test_reset();
        test_add_carry();
        test_add_overflow();
        test_reset_mid_exec();
        test_contention();
        test_backpressure();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
